// File: rtl/bsg_dram_ctrl_app_mem.sv
// ---------------------------------------------------------------------------
// bsg_dram_ctrl_app_mem
//
// Memory-backed stand-in for a DRAM controller's "app" user interface. It
// accepts burst read/write commands plus write-data beats, stores them in an
// internal beat-addressed array, and returns read bursts through a fixed
// latency pipeline. Used for PHY-less FPGA bring-up and as a reference sink.
//
// Ports
//   clk_i                rising-edge clock
//   reset_n_i            asynchronous active-low reset (memory array retained)
//   app_en_i/app_rdy_o   command handshake; accepted when both are high
//   app_cmd_i            3'b000 write, 3'b001 read, anything else is illegal
//   app_addr_i           byte address of the first beat of the burst
//   app_wdf_wren_i       write-data valid; pushed when app_wdf_rdy_o is high
//   app_wdf_rdy_o        write-data FIFO not full
//   app_wdf_data_i       write beat
//   app_wdf_mask_i       per-byte mask, 1 = byte is NOT written
//   app_wdf_end_i        last beat of a write burst
//   app_rd_data_valid_o  read beat valid (no backpressure)
//   app_rd_data_o        read beat
//   app_rd_data_end_o    last beat of a read burst
//   err_o                sticky protocol error (illegal command or misplaced
//                        write end marker), cleared only by reset
// ---------------------------------------------------------------------------
module bsg_dram_ctrl_app_mem #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int burst_len_p  = 2,
  parameter int mem_els_p    = 64,
  parameter int rd_latency_p = 2,
  parameter int wdf_els_p    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic                      app_en_i,
  output logic                      app_rdy_o,
  input  logic [2:0]                app_cmd_i,
  input  logic [addr_width_p-1:0]   app_addr_i,

  input  logic                      app_wdf_wren_i,
  output logic                      app_wdf_rdy_o,
  input  logic [data_width_p-1:0]   app_wdf_data_i,
  input  logic [data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                      app_wdf_end_i,

  output logic                      app_rd_data_valid_o,
  output logic [data_width_p-1:0]   app_rd_data_o,
  output logic                      app_rd_data_end_o,

  output logic                      err_o
);

  localparam int mask_w_lp  = data_width_p / 8;
  localparam int byte_lg_lp = $clog2(mask_w_lp);
  localparam int idx_w_lp   = (mem_els_p > 1)   ? $clog2(mem_els_p)   : 1;
  localparam int cnt_w_lp   = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int ptr_w_lp   = (wdf_els_p > 1)   ? $clog2(wdf_els_p)   : 1;
  localparam int fcnt_w_lp  = $clog2(wdf_els_p + 1);

  localparam logic [cnt_w_lp-1:0]  cnt_last_lp = cnt_w_lp'(burst_len_p - 1);
  localparam logic [fcnt_w_lp-1:0] fcnt_full_lp = fcnt_w_lp'(wdf_els_p);
  localparam logic [ptr_w_lp-1:0]  ptr_last_lp = ptr_w_lp'(wdf_els_p - 1);

  localparam logic [2:0] cmd_write_lp = 3'b000;
  localparam logic [2:0] cmd_read_lp  = 3'b001;

  typedef enum logic [1:0] {
    e_idle,
    e_write,
    e_read
  } state_e;

  // -------------------------------------------------------------------------
  // State and datapath declarations
  // -------------------------------------------------------------------------
  state_e                state_r, state_n;
  logic [idx_w_lp-1:0]   base_r, base_n;
  logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
  logic                  err_r;
  logic                  err_set;
  // Low for the cycles reset is held, so both ready outputs read 0 during
  // reset and come up on the first clock edge after release.
  logic                  alive_r;

  logic [idx_w_lp-1:0]   cur_idx;
  logic                  cnt_is_last;
  logic                  cmd_acc;

  logic                  mem_we;
  logic                  issue_v;
  logic                  issue_end;

  // Write-data FIFO
  logic [data_width_p-1:0] wdf_data_mem [wdf_els_p];
  logic [mask_w_lp-1:0]    wdf_mask_mem [wdf_els_p];
  logic                    wdf_end_mem  [wdf_els_p];
  logic [ptr_w_lp-1:0]     wptr_r, rptr_r;
  logic [fcnt_w_lp-1:0]    fcnt_r, fcnt_n;
  logic                    full_r;
  logic                    wdf_push, wdf_pop, wdf_empty;
  logic [data_width_p-1:0] wdf_head_data;
  logic [mask_w_lp-1:0]    wdf_head_mask;
  logic                    wdf_head_end;

  // Backing store and read pipeline
  logic [data_width_p-1:0] mem_r    [mem_els_p];
  logic                    pipe_v_r [rd_latency_p];
  logic                    pipe_e_r [rd_latency_p];
  logic [data_width_p-1:0] pipe_d_r [rd_latency_p];

  // Address bits below the beat offset and above the memory depth are
  // intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^app_addr_i;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Command side
  // -------------------------------------------------------------------------
  assign app_rdy_o   = alive_r & (state_r == e_idle);
  assign cmd_acc     = app_en_i & app_rdy_o;
  // Truncation to idx_w_lp bits gives the wrap to index 0 at the top.
  assign cur_idx     = base_r + idx_w_lp'(cnt_r);
  assign cnt_is_last = (cnt_r == cnt_last_lp);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state_r;
    base_n    = base_r;
    cnt_n     = cnt_r;
    wdf_pop   = 1'b0;
    mem_we    = 1'b0;
    issue_v   = 1'b0;
    issue_end = 1'b0;
    err_set   = 1'b0;

    unique case (state_r)
      e_idle: begin
        if (cmd_acc) begin
          base_n = idx_w_lp'(app_addr_i >> byte_lg_lp);
          cnt_n  = '0;
          case (app_cmd_i)
            cmd_write_lp: state_n = e_write;
            cmd_read_lp:  state_n = e_read;
            default:      err_set = 1'b1;
          endcase
        end
      end

      e_write: begin
        // An empty FIFO simply stalls the burst.
        if (!wdf_empty) begin
          wdf_pop = 1'b1;
          mem_we  = 1'b1;
          cnt_n   = cnt_r + cnt_w_lp'(1);
          if (wdf_head_end != cnt_is_last) err_set = 1'b1;
          if (cnt_is_last) state_n = e_idle;
        end
      end

      e_read: begin
        issue_v   = 1'b1;
        issue_end = cnt_is_last;
        cnt_n     = cnt_r + cnt_w_lp'(1);
        if (cnt_is_last) state_n = e_idle;
      end

      default: state_n = e_idle;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      base_r  <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      alive_r <= 1'b0;
    end else begin
      state_r <= state_n;
      base_r  <= base_n;
      cnt_r   <= cnt_n;
      err_r   <= err_r | err_set;
      alive_r <= 1'b1;
    end
  end

  assign err_o = err_r;

  // -------------------------------------------------------------------------
  // Write-data FIFO control
  // -------------------------------------------------------------------------
  assign wdf_empty     = (fcnt_r == '0);
  assign app_wdf_rdy_o = alive_r & ~full_r;
  assign wdf_push      = app_wdf_wren_i & app_wdf_rdy_o;
  assign wdf_head_data = wdf_data_mem[rptr_r];
  assign wdf_head_mask = wdf_mask_mem[rptr_r];
  assign wdf_head_end  = wdf_end_mem[rptr_r];

  always_comb begin
    fcnt_n = fcnt_r;
    case ({wdf_push, wdf_pop})
      2'b10:   fcnt_n = fcnt_r + fcnt_w_lp'(1);
      2'b01:   fcnt_n = fcnt_r - fcnt_w_lp'(1);
      default: fcnt_n = fcnt_r;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      fcnt_r <= '0;
      full_r <= 1'b0;
    end else begin
      if (wdf_push) wptr_r <= ptr_inc(wptr_r);
      if (wdf_pop)  rptr_r <= ptr_inc(rptr_r);
      fcnt_r <= fcnt_n;
      full_r <= (fcnt_n == fcnt_full_lp);
    end
  end

  // -------------------------------------------------------------------------
  // Storage: FIFO entries and the backing memory
  // -------------------------------------------------------------------------
  // NOTE: storage arrays have no reset; only the pointers/counters that say
  // which entries are live are reset, and the memory must survive reset.
  always_ff @(posedge clk_i) begin
    if (wdf_push) begin
      wdf_data_mem[wptr_r] <= app_wdf_data_i;
      wdf_mask_mem[wptr_r] <= app_wdf_mask_i;
      wdf_end_mem[wptr_r]  <= app_wdf_end_i;
    end
    if (mem_we) begin
      for (int b = 0; b < mask_w_lp; b++) begin
        if (!wdf_head_mask[b]) mem_r[cur_idx][8*b +: 8] <= wdf_head_data[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read latency pipeline; data is captured from memory at issue time.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < rd_latency_p; i++) begin
        pipe_v_r[i] <= 1'b0;
        pipe_e_r[i] <= 1'b0;
        pipe_d_r[i] <= '0;
      end
    end else begin
      pipe_v_r[0] <= issue_v;
      pipe_e_r[0] <= issue_end;
      if (issue_v) pipe_d_r[0] <= mem_r[cur_idx];
      for (int i = 1; i < rd_latency_p; i++) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
        pipe_e_r[i] <= pipe_e_r[i-1];
        pipe_d_r[i] <= pipe_d_r[i-1];
      end
    end
  end

  assign app_rd_data_valid_o = pipe_v_r[rd_latency_p-1];
  assign app_rd_data_end_o   = pipe_e_r[rd_latency_p-1];
  assign app_rd_data_o       = pipe_d_r[rd_latency_p-1];

endmodule

// File: tb/tb_bsg_dram_ctrl_app_mem.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for bsg_dram_ctrl_app_mem with 32-bit beats,
// 2-beat bursts, 64-beat memory, read latency 2 and a 4-entry write FIFO.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_bsg_dram_ctrl_app_mem;

  localparam int aw_lp  = 12;
  localparam int dw_lp  = 32;
  localparam int bl_lp  = 2;
  localparam int me_lp  = 64;
  localparam int lat_lp = 2;
  localparam int wdf_lp = 4;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              app_en_i = 1'b0;
  logic              app_rdy_o;
  logic [2:0]        app_cmd_i = 3'b000;
  logic [aw_lp-1:0]  app_addr_i = '0;
  logic              app_wdf_wren_i = 1'b0;
  logic              app_wdf_rdy_o;
  logic [dw_lp-1:0]  app_wdf_data_i = '0;
  logic [dw_lp/8-1:0] app_wdf_mask_i = '0;
  logic              app_wdf_end_i = 1'b0;
  logic              app_rd_data_valid_o;
  logic [dw_lp-1:0]  app_rd_data_o;
  logic              app_rd_data_end_o;
  logic              err_o;

  bsg_dram_ctrl_app_mem #(
    .addr_width_p (aw_lp),
    .data_width_p (dw_lp),
    .burst_len_p  (bl_lp),
    .mem_els_p    (me_lp),
    .rd_latency_p (lat_lp),
    .wdf_els_p    (wdf_lp)
  ) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .app_en_i            (app_en_i),
    .app_rdy_o           (app_rdy_o),
    .app_cmd_i           (app_cmd_i),
    .app_addr_i          (app_addr_i),
    .app_wdf_wren_i      (app_wdf_wren_i),
    .app_wdf_rdy_o       (app_wdf_rdy_o),
    .app_wdf_data_i      (app_wdf_data_i),
    .app_wdf_mask_i      (app_wdf_mask_i),
    .app_wdf_end_i       (app_wdf_end_i),
    .app_rd_data_valid_o (app_rd_data_valid_o),
    .app_rd_data_o       (app_rd_data_o),
    .app_rd_data_end_o   (app_rd_data_end_o),
    .err_o               (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!app_rdy_o && n < 50) begin
      step();
      n++;
    end
    if (!app_rdy_o) check("rdy_timeout", 32'(app_rdy_o), 32'd1);
  endtask

  task automatic wait_wdf_rdy();
    int n = 0;
    while (!app_wdf_rdy_o && n < 50) begin
      step();
      n++;
    end
    if (!app_wdf_rdy_o) check("wdf_rdy_timeout", 32'(app_wdf_rdy_o), 32'd1);
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m, input logic e);
    wait_wdf_rdy();
    app_wdf_wren_i = 1'b1;
    app_wdf_data_i = d;
    app_wdf_mask_i = m;
    app_wdf_end_i  = e;
    step();
    app_wdf_wren_i = 1'b0;
  endtask

  // Returns in cycle T+1 of the accepted command.
  task automatic issue_cmd(input logic [2:0] cmd, input logic [11:0] addr);
    wait_rdy();
    app_en_i   = 1'b1;
    app_cmd_i  = cmd;
    app_addr_i = addr;
    step();
    app_en_i   = 1'b0;
  endtask

  // Write command whose whole burst is already buffered: pops at T+1, T+2,
  // ready again at T+3.
  task automatic wr_cmd_timed(input logic [11:0] addr, input string tag);
    issue_cmd(3'b000, addr);
    check({tag, "_rdy_t1"}, 32'(app_rdy_o), 32'd0);
    step();
    check({tag, "_rdy_t2"}, 32'(app_rdy_o), 32'd0);
    step();
    check({tag, "_rdy_t3"}, 32'(app_rdy_o), 32'd1);
  endtask

  task automatic write_burst(input logic [11:0] addr, input logic [31:0] d0,
                             input logic [31:0] d1, input string tag);
    push(d0, 4'h0, 1'b0);
    push(d1, 4'h0, 1'b1);
    wr_cmd_timed(addr, tag);
  endtask

  // Read accepted at T: beats valid at T+3 and T+4, nothing at T+2 or T+5.
  task automatic rd_check(input logic [11:0] addr, input logic [31:0] e0,
                          input logic [31:0] e1, input string tag);
    issue_cmd(3'b001, addr);
    step();
    check({tag, "_v_t2"},   32'(app_rd_data_valid_o), 32'd0);
    check({tag, "_rdy_t2"}, 32'(app_rdy_o), 32'd0);
    step();
    check({tag, "_v_t3"},   32'(app_rd_data_valid_o), 32'd1);
    check({tag, "_d0"},     app_rd_data_o, e0);
    check({tag, "_e_t3"},   32'(app_rd_data_end_o), 32'd0);
    check({tag, "_rdy_t3"}, 32'(app_rdy_o), 32'd1);
    step();
    check({tag, "_v_t4"},   32'(app_rd_data_valid_o), 32'd1);
    check({tag, "_d1"},     app_rd_data_o, e1);
    check({tag, "_e_t4"},   32'(app_rd_data_end_o), 32'd1);
    step();
    check({tag, "_v_t5"},   32'(app_rd_data_valid_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},     32'(app_rdy_o), 32'd0);
    check({tag, "_wdf_rdy"}, 32'(app_wdf_rdy_o), 32'd0);
    check({tag, "_valid"},   32'(app_rd_data_valid_o), 32'd0);
    check({tag, "_end"},     32'(app_rd_data_end_o), 32'd0);
    check({tag, "_err"},     32'(err_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Reset state and bring-up ----------------
    repeat (3) step();
    check_reset_outputs("rst");
    reset_n_i = 1'b1;
    check("rst_rel_rdy", 32'(app_rdy_o), 32'd0);
    step();
    check("up_rdy",     32'(app_rdy_o), 32'd1);
    check("up_wdf_rdy", 32'(app_wdf_rdy_o), 32'd1);

    // ---------------- Write then read ----------------
    write_burst(12'h010, 32'hA5A5A5A5, 32'h5A5A5A5A, "wr10");
    rd_check(12'h010, 32'hA5A5A5A5, 32'h5A5A5A5A, "rd10");

    // ---------------- Byte mask ----------------
    push(32'h12345678, 4'h0, 1'b0);
    push(32'h00000000, 4'h0, 1'b1);
    wr_cmd_timed(12'h020, "wr20a");
    push(32'hFFFFFFFF, 4'b0101, 1'b0);
    push(32'hFFFFFFFF, 4'b1111, 1'b1);
    wr_cmd_timed(12'h020, "wr20b");
    rd_check(12'h020, 32'hFF34FF78, 32'h00000000, "mask");

    // ---------------- Wrap-around ----------------
    write_burst(12'h000, 32'h00000011, 32'h00000022, "wr00");
    write_burst(12'h0FC, 32'h00000001, 32'h00000002, "wrFC");
    rd_check(12'h0FC, 32'h00000001, 32'h00000002, "rdFC");
    rd_check(12'h000, 32'h00000002, 32'h00000022, "rd00");

    // ---------------- Early data: FIFO fills before commands ----------------
    push(32'h000000A1, 4'h0, 1'b0);
    push(32'h000000A2, 4'h0, 1'b1);
    push(32'h000000B1, 4'h0, 1'b0);
    push(32'h000000B2, 4'h0, 1'b1);
    check("early_full", 32'(app_wdf_rdy_o), 32'd0);
    wr_cmd_timed(12'h040, "early1");
    check("early_wdf_rdy1", 32'(app_wdf_rdy_o), 32'd1);
    wr_cmd_timed(12'h048, "early2");
    check("early_wdf_rdy2", 32'(app_wdf_rdy_o), 32'd1);
    rd_check(12'h040, 32'h000000A1, 32'h000000A2, "rd40");
    rd_check(12'h048, 32'h000000B1, 32'h000000B2, "rd48");

    // ---------------- Late data: WRITE stalls ----------------
    issue_cmd(3'b000, 12'h050);
    for (int i = 0; i < 5; i++) begin
      check("late_stall", 32'(app_rdy_o), 32'd0);
      step();
    end
    push(32'h000000C1, 4'h0, 1'b0);
    check("late_after_p1", 32'(app_rdy_o), 32'd0);
    push(32'h000000C2, 4'h0, 1'b1);
    check("late_after_p2", 32'(app_rdy_o), 32'd0);
    step();
    check("late_done", 32'(app_rdy_o), 32'd1);
    check("late_err", 32'(err_o), 32'd0);
    rd_check(12'h050, 32'h000000C1, 32'h000000C2, "rd50");

    // ---------------- Illegal command ----------------
    issue_cmd(3'b010, 12'h010);
    check("ill_err", 32'(err_o), 32'd1);
    check("ill_rdy", 32'(app_rdy_o), 32'd1);
    rd_check(12'h010, 32'hA5A5A5A5, 32'h5A5A5A5A, "ill_rd10");
    check("ill_err_sticky", 32'(err_o), 32'd1);

    // ---------------- Fresh reset, misplaced end marker ----------------
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("rst2");
    step();
    reset_n_i = 1'b1;
    step();
    push(32'h000000D1, 4'h0, 1'b1);
    push(32'h000000D2, 4'h0, 1'b0);
    check("bad_end_pre", 32'(err_o), 32'd0);
    issue_cmd(3'b000, 12'h060);
    step();
    step();
    check("bad_end_err", 32'(err_o), 32'd1);
    check("bad_end_rdy", 32'(app_rdy_o), 32'd1);
    rd_check(12'h060, 32'h000000D1, 32'h000000D2, "rd60");

    // ---------------- Reset in the middle of a read ----------------
    issue_cmd(3'b001, 12'h010);
    step();
    reset_n_i = 1'b0;
    #1;
    check("mid_valid", 32'(app_rd_data_valid_o), 32'd0);
    check("mid_end",   32'(app_rd_data_end_o), 32'd0);
    check("mid_rdy",   32'(app_rdy_o), 32'd0);
    check("mid_err",   32'(err_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_valid_hold", 32'(app_rd_data_valid_o), 32'd0);
    end
    reset_n_i = 1'b1;
    step();
    check("mid_valid_rel", 32'(app_rd_data_valid_o), 32'd0);
    rd_check(12'h010, 32'hA5A5A5A5, 32'h5A5A5A5A, "post_rst_rd10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_dram_ctrl_app_mem.md
# bsg_dram_ctrl_app_mem

Synthesizable memory-backed responder for the DRAM-controller "app" user interface: accepts burst read/write commands and write-data beats, and returns read bursts after a fixed pipeline latency. It sits directly downstream of the cache-to-DRAM-controller bridge, in place of the vendor DRAM controller. It is used for FPGA bring-up without a PHY and as the reference sink in the bridge's testbenches.

## Interface
- `addr_width_p`, "inv": width of `app_addr_i`, a byte address.
- `data_width_p`, "inv": beat width; a multiple of 8 and a power of two.
- `burst_len_p`, "inv": beats per command; a power of two, ≥1.
- `mem_els_p`, "inv": memory depth in beats; a power of two, ≥ `burst_len_p`.
- `rd_latency_p`, 2: cycles from read-beat issue to `app_rd_data_valid_o`; ≥1.
- `wdf_els_p`, 4: write-data FIFO depth in beats; ≥ `burst_len_p`.
- `clk_i` in 1: clock; all state is on the rising edge.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `app_en_i` in 1: command valid.
- `app_rdy_o` out 1: command ready; a command is accepted when `app_en_i & app_rdy_o`.
- `app_cmd_i` in 3: 3'b000 = write, 3'b001 = read, any other value = illegal.
- `app_addr_i` in `addr_width_p`: byte address of the first beat.
- `app_wdf_wren_i` in 1: write-data valid.
- `app_wdf_rdy_o` out 1: write-data ready (FIFO not full).
- `app_wdf_data_i` in `data_width_p`: write beat.
- `app_wdf_mask_i` in `data_width_p/8`: per-byte mask; 1 = byte NOT written.
- `app_wdf_end_i` in 1: marks the last beat of a write burst.
- `app_rd_data_valid_o` out 1: read beat valid. There is no backpressure.
- `app_rd_data_o` out `data_width_p`: read beat.
- `app_rd_data_end_o` out 1: marks the last beat of a read burst.
- `err_o` out 1: sticky protocol-error flag; cleared only by reset.

## Operation
**Address mapping**
- Beat index = `app_addr_i >> log2(data_width_p/8)`, truncated to `log2(mem_els_p)` bits.
- Beat k of a burst uses index (base + k) mod `mem_els_p`. The burst wraps to 0 at the top of memory.

**Write-data FIFO**
- Holds `wdf_els_p` entries of {data, mask, end}.
- Push on `app_wdf_wren_i & app_wdf_rdy_o`. `app_wdf_rdy_o` = !full.
- Write data may arrive before, with, or after its command.

**FSM states**
- IDLE: `app_rdy_o`=1. On accept:
  - write → WRITE.
  - read → READ.
  - illegal → stay in IDLE, command dropped, `err_o` set.
  - Base index and beat counter (0) are latched in every case.
- WRITE: `app_rdy_o`=0. Each cycle the FIFO is non-empty:
  - pop one entry and write the unmasked bytes at the current index;
  - increment the counter.
  - If the FIFO is empty, stall with no state change.
  - If a popped end bit ≠ (counter == `burst_len_p`-1), set `err_o`; the write still occurs.
  - After the pop with counter == `burst_len_p`-1, go to IDLE.
- READ: `app_rdy_o`=0. Issue one beat per cycle into the latency pipeline, with end = (counter == `burst_len_p`-1). After the last issue, go to IDLE.

**Memory**
- Not reset; contents are undefined until written.
- Reads after a completed write burst return the new data.

**Read pipeline**
- `rd_latency_p` stages of {valid, end, data}.
- Data is sampled from memory at issue.

## Timing
- Reset values: `app_rdy_o`=0, `app_wdf_rdy_o`=0, `app_rd_data_valid_o`=0, `app_rd_data_end_o`=0, `err_o`=0. FIFO is empty, FSM is in IDLE, pipeline valids are 0.
  - First cycle after deassertion: `app_rdy_o`=1, `app_wdf_rdy_o`=1.
- Read accepted at cycle T: beat k is issued at T+1+k. Valid beat k appears at T+1+k+`rd_latency_p`. End is high only on beat `burst_len_p`-1.
  - `app_rdy_o` is 1 again at T+1+`burst_len_p`.
  - A back-to-back read gives a gap-free valid stream between the two bursts except one idle beat.
- Write accepted at T with a full burst already buffered: pops occur at T+1..T+`burst_len_p`. `app_rdy_o`=1 at T+1+`burst_len_p`.
- FIFO push and pop in the same cycle are both honoured. `app_wdf_rdy_o` depends only on the registered full flag.
- Reset asserted mid-burst: immediately abort the FSM, flush the FIFO and pipeline, and force outputs to their reset values. Memory is retained.
- `app_addr_i` and `app_cmd_i` are sampled only in the accept cycle.

## Test plan
Parameters: `data_width_p`=32, `burst_len_p`=2, `mem_els_p`=64, `rd_latency_p`=2, `wdf_els_p`=4.
- **Write then read.** Write addr 0x10 with data {0xA5A5A5A5, 0x5A5A5A5A}, mask 0. Then read addr 0x10 accepted at T → valid at T+3 (0xA5A5A5A5) and T+4 (0x5A5A5A5A, end=1).
- **Byte mask.** Write 0xFFFFFFFF over existing 0x12345678 at beat 0 with mask 4'b0101 → read returns 0xFF34FF78.
- **Wrap-around.** Write addr 0xFC (index 63) with {1, 2} → index 63 = 1, index 0 = 2. Read addr 0x0 returns beat 0 = 2.
- **Early/late data.** Push 4 beats before any command → `app_wdf_rdy_o` drops to 0. Then issue 2 write commands; they complete with no stall and rdy returns. Also: a command with data arriving 5 cycles later → WRITE stalls, `app_rdy_o` stays 0 until the second pop.
- **Errors.** `app_cmd_i`=3'b010 → `err_o`=1 next cycle, no data effect. Fresh reset, then write a burst with end set on beat 0 → `err_o`=1 and memory still written.
- **Reset mid-read.** Assert `reset_n_i` at T+2 of a read → `app_rd_data_valid_o` is 0 immediately and stays 0. After release, a read of the same address returns the pre-reset contents.
